mem_arbiter: RTL and testbench

//  Shares one single-port, fixed-latency memory between instruction fetch (IF, read-only)
//  and the data-memory stage (DM, read/write). Sequences each access: arbitrate, issue,

---
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port, fixed-latency memory.
// Fetch (read-only) and data stage (read/write) share one access slot at a time.
module mem_arbiter #(
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned MAX_STARVE = 3
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_data,
    output logic        if_valid,
    output logic        if_stall,

    input  logic        dm_req,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic [15:0] dm_rdata,
    output logic        dm_valid,
    output logic        dm_stall,

    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    localparam int unsigned WCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned SCW = $clog2(MAX_STARVE + 1);
    localparam logic [WCW-1:0] WAIT_LOAD  = WCW'(LATENCY - 1);
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(MAX_STARVE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic            owner_if_q, owner_if_d;
    logic            wr_q, wr_d;
    logic [15:0]     addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [SCW-1:0]  starve_q, starve_d;
    logic [WCW-1:0]  wait_q, wait_d;
    logic [15:0]     if_data_q, if_data_d;
    logic [15:0]     dm_rdata_q, dm_rdata_d;
    logic            if_valid_q, if_valid_d;
    logic            dm_valid_q, dm_valid_d;

    // Fetch only wins once the data stage has taken MAX_STARVE grants in a row over it.
    logic grant_if;
    assign grant_if = if_req & (~dm_req | (starve_q == STARVE_MAX));

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        owner_if_d = owner_if_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        starve_d   = starve_q;
        wait_d     = wait_q;
        if_data_d  = if_data_q;
        dm_rdata_d = dm_rdata_q;
        if_valid_d = 1'b0;
        dm_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (if_req || dm_req) begin
                    state_d    = S_ISSUE;
                    owner_if_d = grant_if;
                    if (grant_if) begin
                        addr_d   = if_addr;
                        wr_d     = 1'b0;
                        starve_d = '0;
                    end else begin
                        addr_d  = dm_addr;
                        wr_d    = dm_wr;
                        wdata_d = dm_wdata;
                        if (if_req && (starve_q != STARVE_MAX)) begin
                            starve_d = starve_q + 1'b1;
                        end else if (!if_req) begin
                            starve_d = '0;
                        end
                    end
                end else begin
                    starve_d = '0;
                end
            end

            S_ISSUE: begin
                wait_d  = WAIT_LOAD;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (wait_q == '0) begin
                    // Capture on the last wait cycle so the valid pulse and its data line up in RESP.
                    if (!wr_q) begin
                        if (owner_if_q) begin
                            if_data_d = mem_rdata;
                        end else begin
                            dm_rdata_d = mem_rdata;
                        end
                    end
                    if_valid_d = owner_if_q;
                    dm_valid_d = ~owner_if_q;
                    state_d    = S_RESP;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: the data-return registers are reset too, because every output must read 0 during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            owner_if_q <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            starve_q   <= '0;
            wait_q     <= '0;
            if_data_q  <= '0;
            dm_rdata_q <= '0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the same pre-edge values.
            state_q    <= state_d;
            owner_if_q <= owner_if_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            starve_q   <= starve_d;
            wait_q     <= wait_d;
            if_data_q  <= if_data_d;
            dm_rdata_q <= dm_rdata_d;
            if_valid_q <= if_valid_d;
            dm_valid_q <= dm_valid_d;
        end
    end

    assign mem_en    = (state_q == S_ISSUE);
    assign mem_wr    = mem_en & wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_data   = if_data_q;
    assign if_valid  = if_valid_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_valid  = dm_valid_q;

    // Stall falls in the valid cycle so the pipeline advances exactly on the pulse.
    assign if_stall  = if_req & ~if_valid_q;
    assign dm_stall  = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed latencies and data.
module tb_mem_arbiter;

    localparam int LAT  = 4;
    localparam int MAXS = 3;

    logic        clk;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic [15:0] if_data;
    logic        if_valid, if_stall;
    logic        dm_req = 1'b0;
    logic        dm_wr = 1'b0;
    logic [15:0] dm_addr = '0;
    logic [15:0] dm_wdata = '0;
    logic [15:0] dm_rdata;
    logic        dm_valid, dm_stall;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mem_arbiter #(.LATENCY(LAT), .MAX_STARVE(MAXS)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data),
        .if_valid(if_valid), .if_stall(if_stall),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory macro: result appears LAT cycles after the mem_en cycle, garbage otherwise.
    logic [15:0] mem [256];
    logic [15:0] mem_pend;
    int          mem_cnt = 0;
    bit          mem_act = 1'b0;
    bit          mem_loaded = 1'b0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'(i * 3);
            mem[8'h00] <= 16'h0F0F;
            mem[8'h10] <= 16'hBEEF;
            mem[8'h30] <= 16'hAAAA;
            mem[8'h31] <= 16'h5555;
            mem_loaded <= 1'b1;
        end else if (mem_en) begin
            if (mem_wr) mem[mem_addr[7:0]] <= mem_wdata;
            mem_pend <= mem[mem_addr[7:0]];
            mem_cnt  <= LAT - 1;
            mem_act  <= 1'b1;
        end else if (mem_act) begin
            if (mem_cnt == 0) mem_act <= 1'b0;
            else mem_cnt <= mem_cnt - 1;
        end
    end
    assign mem_rdata = (mem_act && mem_cnt == 0) ? mem_pend : 16'hDEAD;

    // Reference model: an access is a numbered sequence of cycles after its grant
    // (1 = strobe, LAT+2 = completion), with its own copy of memory contents.
    logic [15:0] mm [256];
    bit          mm_loaded = 1'b0;
    bit          m_busy;
    int          m_phase, m_starve;
    bit          m_owner_if, m_wr;
    logic [15:0] m_addr, m_wdata, m_if_data, m_dm_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (!mm_loaded) begin
                for (int i = 0; i < 256; i++) mm[i] <= 16'(i * 3);
                mm[8'h00] <= 16'h0F0F;
                mm[8'h10] <= 16'hBEEF;
                mm[8'h30] <= 16'hAAAA;
                mm[8'h31] <= 16'h5555;
                mm_loaded <= 1'b1;
            end
            m_busy <= 1'b0; m_phase <= 0; m_starve <= 0;
            m_owner_if <= 1'b0; m_wr <= 1'b0; m_addr <= '0; m_wdata <= '0;
            m_if_data <= '0; m_dm_data <= '0;
        end else if (m_busy) begin
            m_phase <= m_phase + 1;
            if (m_phase == LAT + 2) m_busy <= 1'b0;
            if (m_phase == 1 && m_wr) mm[m_addr[7:0]] <= m_wdata;
            if (m_phase == LAT + 1 && !m_wr) begin
                if (m_owner_if) m_if_data <= mm[m_addr[7:0]];
                else m_dm_data <= mm[m_addr[7:0]];
            end
        end else if (if_req || dm_req) begin
            m_busy <= 1'b1;
            m_phase <= 1;
            if (if_req && (!dm_req || m_starve == MAXS)) begin
                m_owner_if <= 1'b1; m_addr <= if_addr; m_wr <= 1'b0; m_starve <= 0;
            end else begin
                m_owner_if <= 1'b0; m_addr <= dm_addr; m_wr <= dm_wr; m_wdata <= dm_wdata;
                m_starve <= if_req ? ((m_starve < MAXS) ? m_starve + 1 : MAXS) : 0;
            end
        end else begin
            m_starve <= 0;
        end
    end

    always @(negedge clk) begin
        bit e_en, e_ifv, e_dmv;
        e_en  = m_busy && m_phase == 1;
        e_ifv = m_busy && m_phase == LAT + 2 && m_owner_if;
        e_dmv = m_busy && m_phase == LAT + 2 && !m_owner_if;
        check("mem_en", mem_en, e_en);
        check("mem_wr", mem_wr, e_en && m_wr);
        check("if_valid", if_valid, e_ifv);
        check("dm_valid", dm_valid, e_dmv);
        check("if_data", if_data, m_if_data);
        check("dm_rdata", dm_rdata, m_dm_data);
        check("if_stall", if_stall, if_req && !e_ifv);
        check("dm_stall", dm_stall, dm_req && !e_dmv);
        if (m_busy && m_phase <= LAT + 1) check("mem_addr", mem_addr, m_addr);
        if (e_en && m_wr) check("mem_wdata", mem_wdata, m_wdata);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input bit on_if, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (on_if ? if_valid : dm_valid) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check(on_if ? "if_valid_timeout" : "dm_valid_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, a1, a2, n_en, n_val;
        logic [15:0] grants [$];
        logic [15:0] exp4 [5];
        exp4[0] = 16'h0050; exp4[1] = 16'h0050; exp4[2] = 16'h0050;
        exp4[3] = 16'h0040; exp4[4] = 16'h0050;

        // Reset: every output low, then quiet until a request arrives.
        repeat (3) @(negedge clk);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_dm_valid", dm_valid, 0);
        check("rst_if_data", if_data, 0);
        check("rst_dm_rdata", dm_rdata, 0);
        tick();
        rst_n = 1'b1;
        n_en = 0;
        repeat (5) begin
            @(negedge clk);
            if (mem_en) n_en++;
        end
        check("idle_no_mem_en", n_en, 0);
        tick();

        // IF read alone.
        t = cyc;
        if_req = 1'b1; if_addr = 16'h0010;
        @(negedge clk);
        check("if_stall_at_t", if_stall, 1);
        wait_valid(1'b1, a1);
        check("if_latency", a1 - t, 6);
        check("if_data_beef", if_data, 16'hBEEF);
        check("if_stall_on_pulse", if_stall, 0);
        tick();
        if_req = 1'b0;
        tick();

        // Simultaneous IF read and DM write: DM first, IF right after.
        t = cyc;
        if_req = 1'b1; if_addr = 16'h0000;
        dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0020; dm_wdata = 16'h1234;
        wait_valid(1'b0, a1);
        check("dm_wr_latency", a1 - t, 6);
        tick();
        dm_req = 1'b0; dm_wr = 1'b0;
        wait_valid(1'b1, a2);
        check("if_after_dm_latency", a2 - t, 13);
        check("if_data_0f0f", if_data, 16'h0F0F);
        tick();
        if_req = 1'b0;
        t = cyc;
        dm_req = 1'b1; dm_addr = 16'h0020;
        wait_valid(1'b0, a1);
        check("dm_rd_latency", a1 - t, 6);
        check("dm_readback_1234", dm_rdata, 16'h1234);
        tick();
        dm_req = 1'b0;
        tick();

        // Both held: three DM grants, then forced IF, then DM again.
        if_req = 1'b1; if_addr = 16'h0040;
        dm_req = 1'b1; dm_addr = 16'h0050;
        repeat (40) begin
            @(negedge clk);
            if (mem_en) grants.push_back(mem_addr);
        end
        check("starve_grant_count_ge5", grants.size() >= 5, 1);
        for (int i = 0; i < 5; i++) begin
            if (i < grants.size()) check("starve_grant_order", grants[i], exp4[i]);
        end
        tick();
        if_req = 1'b0; dm_req = 1'b0;
        repeat (10) tick();

        // Reset in the middle of a DM read's wait.
        t = cyc;
        dm_req = 1'b1; dm_addr = 16'h0030;
        repeat (3) tick();
        rst_n = 1'b0;
        dm_req = 1'b0;
        @(negedge clk);
        check("abort_mem_en", mem_en, 0);
        check("abort_dm_valid", dm_valid, 0);
        check("abort_mem_addr", mem_addr, 0);
        tick();
        tick();
        rst_n = 1'b1;
        n_en = 0; n_val = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_en) n_en++;
            if (dm_valid) n_val++;
        end
        check("abort_no_mem_en", n_en, 0);
        check("abort_no_dm_valid", n_val, 0);
        tick();
        t = cyc;
        dm_req = 1'b1; dm_addr = 16'h0031;
        wait_valid(1'b0, a1);
        check("post_reset_latency", a1 - t, 6);
        check("post_reset_data", dm_rdata, 16'h5555);
        tick();
        dm_req = 1'b0;
        tick();

        // Back-to-back DM reads, seven cycles apart, data held between pulses.
        t = cyc;
        dm_req = 1'b1; dm_addr = 16'h0030;
        wait_valid(1'b0, a1);
        check("b2b_first_latency", a1 - t, 6);
        check("b2b_first_data", dm_rdata, 16'hAAAA);
        tick();
        dm_addr = 16'h0031;
        repeat (3) @(negedge clk);
        check("b2b_hold", dm_rdata, 16'hAAAA);
        wait_valid(1'b0, a2);
        check("b2b_spacing", a2 - a1, 7);
        check("b2b_second_data", dm_rdata, 16'h5555);
        tick();
        dm_req = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
